// File: rtl/mux4_1_rr_pkg.sv
// Shared definitions for the mux/demux channel family: channel count, select type,
// output-stage states and the wrap-around select increment.
package mux_demux_pkg;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_t;

    // Width of sel_t makes the increment wrap 3 -> 0 for free.
    function automatic sel_t sel_inc(input sel_t s);
        return s + sel_t'(1);
    endfunction
endpackage

// File: rtl/mux4_1_rr_if.sv
// Channel bundle of the 4-to-1 collector: four valid/accept sources, one valid/ready sink.
interface mux4_1_rr_if #(
    parameter int W = 8
);
    logic         e;
    logic [W-1:0] d0, d1, d2, d3;
    logic         v0, v1, v2, v3;
    logic         r0, r1, r2, r3;
    logic [W-1:0] y;
    logic         a, b;
    logic         y_valid;
    logic         y_ready;

    modport master (
        output e, d0, d1, d2, d3, v0, v1, v2, v3, y_ready,
        input  r0, r1, r2, r3, y, a, b, y_valid
    );

    modport slave (
        input  e, d0, d1, d2, d3, v0, v1, v2, v3, y_ready,
        output r0, r1, r2, r3, y, a, b, y_valid
    );
endinterface

// File: rtl/mux4_1_rr_arb.sv
// Combinational 4-way round-robin arbiter: first requester found scanning from ptr upward,
// wrapping 3 -> 0.
module rr_arb4
    import mux_demux_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  sel_t            ptr,
    output logic [N_CH-1:0] gnt,
    output sel_t            gidx,
    output logic            any
);
    logic found;
    sel_t cand;

    always_comb begin
        gnt   = '0;
        gidx  = ptr;
        found = 1'b0;
        cand  = ptr;
        for (int k = 0; k < N_CH; k++) begin
            cand = ptr + sel_t'(k);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                gidx      = cand;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/mux4_1_rr.sv
// 4-to-1 round-robin collector into a single-entry output stage tagged with the
// source channel index {a,b}.
module mux4_1_rr
    import mux_demux_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    mux4_1_rr_if.slave   bus
);
    logic [N_CH-1:0][W-1:0] d_arr;
    logic [N_CH-1:0]        req;
    logic [N_CH-1:0]        gnt;
    logic [N_CH-1:0]        r;
    sel_t                   gidx;
    logic                   any;
    logic                   space;
    logic                   accept;

    stage_t                 state_q, state_d;
    sel_t                   ptr_q;
    sel_t                   idx_q;
    logic [W-1:0]           y_q;

    assign d_arr = {bus.d3, bus.d2, bus.d1, bus.d0};
    assign req   = {bus.v3, bus.v2, bus.v1, bus.v0};

    rr_arb4 u_arb (
        .req  (req),
        .ptr  (ptr_q),
        .gnt  (gnt),
        .gidx (gidx),
        .any  (any)
    );

    // rst_n gates accept so no source sees a strobe while reset is held.
    assign space  = (state_q == EMPTY) | bus.y_ready;
    assign accept = rst_n & bus.e & space & any;
    assign r      = accept ? gnt : '0;

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = FULL;
        else if (state_q == FULL && bus.y_ready)
            state_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            idx_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                y_q   <= d_arr[gidx];
                idx_q <= gidx;
                ptr_q <= sel_inc(gidx);
            end
        end
    end

    assign bus.r0      = r[0];
    assign bus.r1      = r[1];
    assign bus.r2      = r[2];
    assign bus.r3      = r[3];
    assign bus.y       = y_q;
    assign bus.a       = idx_q[1];
    assign bus.b       = idx_q[0];
    assign bus.y_valid = (state_q == FULL);
endmodule

// File: tb/tb_mux4_1_rr.sv
// Table-driven cycle checks of mux4_1_rr with a scoreboard pairing accepted words to
// the words the output stage hands downstream.
module tb_mux4_1_rr;
    logic clk;
    logic rst_n;

    mux4_1_rr_if #(.W(8)) bus ();

    mux4_1_rr #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            e;
        logic [3:0]      v;
        logic            rdy;
        logic [3:0][7:0] d;
        logic [3:0]      er;
        logic            evld;
        logic [7:0]      ey;
        logic [1:0]      eab;
    } vec_t;

    typedef struct packed {
        logic [7:0] y;
        logic [1:0] ab;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic [3:0] v, input logic rdy,
                                input logic [3:0][7:0] d, input logic [3:0] er,
                                input logic evld, input logic [7:0] ey, input logic [1:0] eab);
        vec_t t;
        t.e = e; t.v = v; t.rdy = rdy; t.d = d;
        t.er = er; t.evld = evld; t.ey = ey; t.eab = eab;
        return t;
    endfunction

    task automatic drive(input logic e, input logic [3:0] v, input logic rdy,
                         input logic [3:0][7:0] d);
        bus.e = e;
        {bus.v3, bus.v2, bus.v1, bus.v0} = v;
        bus.y_ready = rdy;
        bus.d0 = d[0]; bus.d1 = d[1]; bus.d2 = d[2]; bus.d3 = d[3];
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well before the
    // next rising edge.
    task automatic apply(input vec_t t, input int idx);
        sb_t s;
        @(negedge clk);
        drive(t.e, t.v, t.rdy, t.d);
        #1;
        chk($sformatf("row%0d_r", idx), {bus.r3, bus.r2, bus.r1, bus.r0}, t.er);
        chk($sformatf("row%0d_y_valid", idx), bus.y_valid, t.evld);
        chk($sformatf("row%0d_y", idx), bus.y, t.ey);
        chk($sformatf("row%0d_ab", idx), {bus.a, bus.b}, t.eab);
        if (bus.y_valid && bus.y_ready) begin
            if (sb.size() == 0) begin
                chk($sformatf("row%0d_sb_underflow", idx), 1, 0);
            end else begin
                s = sb.pop_front();
                chk($sformatf("row%0d_sb_y", idx), bus.y, s.y);
                chk($sformatf("row%0d_sb_ab", idx), {bus.a, bus.b}, s.ab);
            end
        end
        for (int g = 0; g < 4; g++)
            if (t.er[g]) sb.push_back('{y: t.d[g], ab: 2'(g)});
    endtask

    localparam logic [3:0][7:0] D  = {8'h13, 8'h12, 8'h11, 8'h10};
    localparam logic [3:0][7:0] DA = {8'h13, 8'hA5, 8'h11, 8'h10};

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 4'b0000, 1'b0, D);
        #2;
        chk("reset_y_valid", bus.y_valid, 0);
        chk("reset_y", bus.y, 0);
        chk("reset_ab", {bus.a, bus.b}, 0);
        chk("reset_r", {bus.r3, bus.r2, bus.r1, bus.r0}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin from ptr=0, including back-to-back drain+accept.
        tbl.push_back(mk(1, 4'b1111, 1, D, 4'b0001, 0, 8'h00, 2'd0));
        tbl.push_back(mk(1, 4'b1111, 1, D, 4'b0010, 1, 8'h10, 2'd0));
        tbl.push_back(mk(1, 4'b1111, 1, D, 4'b0100, 1, 8'h11, 2'd1));
        tbl.push_back(mk(1, 4'b1111, 1, D, 4'b1000, 1, 8'h12, 2'd2));
        tbl.push_back(mk(1, 4'b1111, 1, D, 4'b0001, 1, 8'h13, 2'd3));
        tbl.push_back(mk(1, 4'b0000, 1, D, 4'b0000, 1, 8'h10, 2'd0));
        // Single source on channel 2; y/ab hold last values while EMPTY.
        tbl.push_back(mk(1, 4'b0100, 1, DA, 4'b0100, 0, 8'h10, 2'd0));
        tbl.push_back(mk(1, 4'b0000, 1, DA, 4'b0000, 1, 8'hA5, 2'd2));
        // ptr=3, only ch1 -> grant 1, ptr=2; then ch0+ch3 -> 3 then 0.
        tbl.push_back(mk(1, 4'b0010, 1, D, 4'b0010, 0, 8'hA5, 2'd2));
        tbl.push_back(mk(1, 4'b1001, 1, D, 4'b1000, 1, 8'h11, 2'd1));
        tbl.push_back(mk(1, 4'b0001, 1, D, 4'b0001, 1, 8'h13, 2'd3));
        tbl.push_back(mk(1, 4'b0000, 1, D, 4'b0000, 1, 8'h10, 2'd0));
        // Backpressure: FULL with 0x11, three stall cycles, then drain+accept of ch0.
        tbl.push_back(mk(1, 4'b0010, 1, D, 4'b0010, 0, 8'h10, 2'd0));
        tbl.push_back(mk(1, 4'b0001, 0, D, 4'b0000, 1, 8'h11, 2'd1));
        tbl.push_back(mk(1, 4'b0001, 0, D, 4'b0000, 1, 8'h11, 2'd1));
        tbl.push_back(mk(1, 4'b0001, 0, D, 4'b0000, 1, 8'h11, 2'd1));
        tbl.push_back(mk(1, 4'b0001, 1, D, 4'b0001, 1, 8'h11, 2'd1));
        tbl.push_back(mk(1, 4'b0000, 1, D, 4'b0000, 1, 8'h10, 2'd0));
        // Enable low: drain still happens, nothing new taken, ptr frozen at 3.
        tbl.push_back(mk(1, 4'b0100, 1, D, 4'b0100, 0, 8'h10, 2'd0));
        tbl.push_back(mk(0, 4'b0010, 1, D, 4'b0000, 1, 8'h12, 2'd2));
        tbl.push_back(mk(0, 4'b0010, 1, D, 4'b0000, 0, 8'h12, 2'd2));
        tbl.push_back(mk(1, 4'b0010, 1, D, 4'b0010, 0, 8'h12, 2'd2));
        tbl.push_back(mk(1, 4'b0000, 1, D, 4'b0000, 1, 8'h11, 2'd1));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);
        chk("sb_empty", sb.size(), 0);

        // Asynchronous reset while the stage holds a word and a source is still valid.
        @(negedge clk);
        drive(1'b1, 4'b0001, 1'b0, D);
        @(negedge clk);
        #1;
        chk("pre_reset_y_valid", bus.y_valid, 1);
        chk("pre_reset_y", bus.y, 8'h10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_y_valid", bus.y_valid, 0);
        chk("async_reset_y", bus.y, 0);
        chk("async_reset_ab", {bus.a, bus.b}, 0);
        chk("async_reset_r", {bus.r3, bus.r2, bus.r1, bus.r0}, 0);
        sb.delete();
        @(negedge clk);
        drive(1'b0, 4'b0000, 1'b1, D);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
